// File: rtl/ethernet_rx_header_parser_if.sv
// Framed 32-bit byte stream between the MAC and the header parser.
// The first byte of each word sits in data[31:24]; bytes_valid counts the leading valid bytes.
interface ethernet_rx_header_parser_if;
  logic        start;
  logic        data_valid;
  logic [2:0]  bytes_valid;
  logic [31:0] data;
  logic        commit;
  logic        drop;

  modport master (output start, data_valid, bytes_valid, data, commit, drop);
  modport slave  (input  start, data_valid, bytes_valid, data, commit, drop);
endinterface

// File: rtl/ethernet_rx_header_parser.sv
// Ethernet RX header parser: filters on destination MAC, strips one optional 802.1Q tag,
// and realigns the payload so that its first byte leads each output word.
//
// state   | meaning
// IDLE    | waiting for rx.start
// HEADER  | collecting MAC addresses, optional VLAN tag and ethertype
// BODY    | realigning payload bytes, one output word per input word
// DISCARD | frame rejected or runt, swallow words until commit/drop
module ethernet_rx_header_parser #(
  parameter bit VLAN_ENABLE = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [47:0]                        our_mac,
  input  logic                               promisc,
  ethernet_rx_header_parser_if.slave         rx,
  ethernet_rx_header_parser_if.master        out,
  output logic                               hdr_valid,
  output logic [47:0]                        dst_mac,
  output logic [47:0]                        src_mac,
  output logic [15:0]                        ethertype,
  output logic                               vlan_valid,
  output logic [11:0]                        vlan_id
);

  typedef enum logic [1:0] {IDLE, HEADER, BODY, DISCARD} state_t;

  state_t      state, state_next;
  logic [2:0]  hdr_cnt;
  logic [47:0] dst_r, src_r;
  logic [11:0] vid_r;
  logic        vlan_seen;
  logic [23:0] carry;
  logic [1:0]  carry_cnt;
  logic        frame_open;
  logic        close_pend, close_commit;

  logic        full_word, dst_ok, is_tpid, type_word, hdr_done, frame_end;
  logic [47:0] dst_cand;
  logic [31:0] data_m;
  logic [2:0]  n_eff, fill;
  logic [55:0] merged;

  assign full_word = (rx.bytes_valid == 3'd4);
  assign dst_cand  = {dst_r[47:16], rx.data[31:16]};
  assign dst_ok    = (dst_cand == our_mac) || dst_cand[40] || promisc;
  assign is_tpid   = VLAN_ENABLE && (rx.data[31:16] == 16'h8100);
  assign type_word = (hdr_cnt == 3'd4) || ((hdr_cnt == 3'd3) && !is_tpid);
  assign frame_end = rx.commit || rx.drop;

  // Only the leading bytes_valid bytes take part in realignment; the rest are forced to zero.
  always_comb begin
    data_m = 32'h0;
    n_eff  = 3'd0;
    case (rx.bytes_valid)
      3'd1: begin data_m = {rx.data[31:24], 24'h0}; n_eff = 3'd1; end
      3'd2: begin data_m = {rx.data[31:16], 16'h0}; n_eff = 3'd2; end
      3'd3: begin data_m = {rx.data[31:8], 8'h0};   n_eff = 3'd3; end
      3'd4: begin data_m = rx.data;                 n_eff = 3'd4; end
      default: ;
    endcase
  end

  // Carry bytes followed directly by the new bytes, as a 7-byte left-justified window.
  assign merged = {carry, 32'h0} | ({data_m, 24'h0} >> {carry_cnt, 3'b000});
  assign fill   = {1'b0, carry_cnt} + n_eff;

  always_comb begin
    state_next = state;
    hdr_done   = 1'b0;
    if (rx.start) begin
      state_next = HEADER;
    end else begin
      case (state)
        IDLE: ;
        HEADER: begin
          if (frame_end) begin
            state_next = IDLE;
          end else if (rx.data_valid) begin
            if (!full_word) begin
              state_next = DISCARD;
            end else if ((hdr_cnt == 3'd1) && !dst_ok) begin
              state_next = DISCARD;
            end else if (type_word) begin
              hdr_done   = 1'b1;
              state_next = BODY;
            end
          end
        end
        BODY:    if (frame_end) state_next = IDLE;
        DISCARD: if (frame_end) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_cnt          <= 3'd0;
      dst_r            <= 48'h0;
      src_r            <= 48'h0;
      vid_r            <= 12'h0;
      vlan_seen        <= 1'b0;
      carry            <= 24'h0;
      carry_cnt        <= 2'd0;
      frame_open       <= 1'b0;
      close_pend       <= 1'b0;
      close_commit     <= 1'b0;
      hdr_valid        <= 1'b0;
      dst_mac          <= 48'h0;
      src_mac          <= 48'h0;
      ethertype        <= 16'h0;
      vlan_valid       <= 1'b0;
      vlan_id          <= 12'h0;
      out.start        <= 1'b0;
      out.data_valid   <= 1'b0;
      out.bytes_valid  <= 3'd0;
      out.data         <= 32'h0;
      out.commit       <= 1'b0;
      out.drop         <= 1'b0;
    end else begin
      hdr_valid        <= 1'b0;
      out.start        <= 1'b0;
      out.data_valid   <= 1'b0;
      out.bytes_valid  <= 3'd0;
      out.data         <= 32'h0;
      out.commit       <= 1'b0;
      out.drop         <= 1'b0;

      // Close that was deferred behind the final partial word.
      if (close_pend) begin
        close_pend <= 1'b0;
        if (close_commit) out.commit <= 1'b1;
        else              out.drop   <= 1'b1;
      end

      if (rx.start) begin
        hdr_cnt   <= 3'd0;
        carry     <= 24'h0;
        carry_cnt <= 2'd0;
        vlan_seen <= 1'b0;
        if (frame_open) begin
          out.drop   <= 1'b1;
          frame_open <= 1'b0;
        end
      end else begin
        case (state)
          HEADER: begin
            if (rx.data_valid && !frame_end && full_word) begin
              hdr_cnt <= hdr_cnt + 3'd1;
              case (hdr_cnt)
                3'd0: dst_r[47:16] <= rx.data;
                3'd1: begin
                  dst_r[15:0]  <= rx.data[31:16];
                  src_r[47:32] <= rx.data[15:0];
                end
                3'd2: src_r[31:0] <= rx.data;
                3'd3: if (is_tpid) begin
                  vid_r     <= rx.data[11:0];
                  vlan_seen <= 1'b1;
                end
                default: ;
              endcase
              if (hdr_done) begin
                hdr_valid  <= 1'b1;
                out.start  <= 1'b1;
                frame_open <= 1'b1;
                dst_mac    <= dst_r;
                src_mac    <= src_r;
                ethertype  <= rx.data[31:16];
                vlan_valid <= vlan_seen;
                vlan_id    <= vlan_seen ? vid_r : 12'h0;
                carry      <= {rx.data[15:0], 8'h0};
                carry_cnt  <= 2'd2;
              end
            end
          end
          BODY: begin
            if (frame_end) begin
              frame_open <= 1'b0;
              carry      <= 24'h0;
              carry_cnt  <= 2'd0;
              if (carry_cnt != 2'd0) begin
                out.data_valid  <= 1'b1;
                out.data        <= {carry, 8'h0};
                out.bytes_valid <= {1'b0, carry_cnt};
                close_pend      <= 1'b1;
                close_commit    <= rx.commit;
              end else if (rx.commit) begin
                out.commit <= 1'b1;
              end else begin
                out.drop <= 1'b1;
              end
            end else if (rx.data_valid && (n_eff != 3'd0)) begin
              // fill is 4..7 when a word completes, so fill[1:0] is the leftover count either way.
              carry_cnt <= fill[1:0];
              if (fill[2]) begin
                out.data_valid  <= 1'b1;
                out.data        <= merged[55:24];
                out.bytes_valid <= 3'd4;
                carry           <= merged[23:0];
              end else begin
                carry <= merged[55:32];
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ethernet_rx_header_parser.sv
// Directed bench for ethernet_rx_header_parser: per-cycle vector table checked against a byte-queue
// model of the payload stream, plus a reset-mid-frame sequence.
module tb_ethernet_rx_header_parser;
  localparam logic [47:0] OUR_MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] SRC_MAC = 48'h00_11_22_33_44_55;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] our_mac;
  logic        promisc;
  logic        hdr_valid;
  logic [47:0] dst_mac, src_mac;
  logic [15:0] ethertype;
  logic        vlan_valid;
  logic [11:0] vlan_id;

  ethernet_rx_header_parser_if rx_if ();
  ethernet_rx_header_parser_if out_if ();

  ethernet_rx_header_parser #(.VLAN_ENABLE(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .our_mac    (our_mac),
    .promisc    (promisc),
    .rx         (rx_if),
    .out        (out_if),
    .hdr_valid  (hdr_valid),
    .dst_mac    (dst_mac),
    .src_mac    (src_mac),
    .ethertype  (ethertype),
    .vlan_valid (vlan_valid),
    .vlan_id    (vlan_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        dv;
    logic [2:0]  bv;
    logic [31:0] data;
    logic        commit;
    logic        drop;
    logic        prom;
    logic [39:0] exp_out;
    logic        chk_hdr;
    logic [47:0] e_dst;
    logic [47:0] e_src;
    logic [15:0] e_et;
    logic        e_vv;
    logic [11:0] e_vid;
    string       name;
  } vec_t;

  vec_t vq[$];
  int   n_chk;
  int   n_pass;
  logic prom_cur;
  bit   open_cur;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [39:0] outs();
    return {hdr_valid, out_if.start, out_if.data_valid, out_if.bytes_valid, out_if.data,
            out_if.commit, out_if.drop};
  endfunction

  function automatic logic [39:0] eo(input logic hv, input logic st, input logic dv,
                                     input logic [2:0] bv, input logic [31:0] d,
                                     input logic cm, input logic dr);
    return {hv, st, dv, bv, d, cm, dr};
  endfunction

  function automatic void add(input logic st, input logic dv, input logic [2:0] bv,
                              input logic [31:0] d, input logic cm, input logic dr,
                              input logic [39:0] e, input string nm);
    vec_t v;
    v.start = st; v.dv = dv; v.bv = bv; v.data = d; v.commit = cm; v.drop = dr;
    v.prom = prom_cur; v.exp_out = e; v.chk_hdr = 1'b0;
    v.e_dst = 48'h0; v.e_src = 48'h0; v.e_et = 16'h0; v.e_vv = 1'b0; v.e_vid = 12'h0;
    v.name = nm;
    vq.push_back(v);
  endfunction

  // endk: 0 = commit, 1 = drop, 2 = leave the frame open
  task automatic add_frame(input logic [47:0] dst, input bit vl, input logic [15:0] tci,
                           input logic [15:0] et, input int plen, input int endk,
                           input string nm);
    logic [7:0]  fb[$];
    logic [7:0]  pq[$];
    int          hdrw, nw, n, last;
    bit          acc;
    logic [31:0] d, wd;
    logic [39:0] e;
    acc = (dst == OUR_MAC) || dst[40] || prom_cur;
    add(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, eo(0, 0, 0, 3'd0, 32'h0, 0, open_cur),
        {nm, " start"});
    open_cur = 1'b0;
    for (int i = 0; i < 6; i++) fb.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) fb.push_back(SRC_MAC[47-8*i -: 8]);
    if (vl) begin
      fb.push_back(8'h81); fb.push_back(8'h00); fb.push_back(tci[15:8]); fb.push_back(tci[7:0]);
    end
    fb.push_back(et[15:8]); fb.push_back(et[7:0]);
    for (int k = 0; k < plen; k++) fb.push_back(8'((k * 7 + 3) & 255));
    hdrw = vl ? 5 : 4;
    nw   = (fb.size() + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      n = fb.size() - 4 * w;
      if (n > 4) n = 4;
      d = 32'h0;
      for (int b = 0; b < n; b++) d[31-8*b -: 8] = fb[4*w+b];
      e = 40'h0;
      if (acc && w == hdrw - 1) begin
        e = eo(1, 1, 0, 3'd0, 32'h0, 0, 0);
        pq.push_back(fb[4*w+2]);
        pq.push_back(fb[4*w+3]);
        open_cur = 1'b1;
      end else if (acc && w >= hdrw) begin
        for (int b = 0; b < n; b++) pq.push_back(fb[4*w+b]);
        if (pq.size() >= 4) begin
          wd = {pq[0], pq[1], pq[2], pq[3]};
          repeat (4) void'(pq.pop_front());
          e = eo(0, 0, 1, 3'd4, wd, 0, 0);
        end
      end
      add(1'b0, 1'b1, 3'(n), d, 1'b0, 1'b0, e, $sformatf("%s w%0d", nm, w));
      if (acc && w == hdrw - 1) begin
        last = vq.size() - 1;
        vq[last].chk_hdr = 1'b1;
        vq[last].e_dst   = dst;
        vq[last].e_src   = SRC_MAC;
        vq[last].e_et    = et;
        vq[last].e_vv    = vl;
        vq[last].e_vid   = vl ? tci[11:0] : 12'h0;
      end
    end
    if (endk != 2 && acc) begin
      wd = 32'h0;
      for (int b = 0; b < pq.size(); b++) wd[31-8*b -: 8] = pq[b];
      if (pq.size() > 0) begin
        add(1'b0, 1'b0, 3'd0, 32'h0, endk == 0, endk == 1,
            eo(0, 0, 1, 3'(pq.size()), wd, 0, 0), {nm, " end"});
        add(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0,
            eo(0, 0, 0, 3'd0, 32'h0, endk == 0, endk == 1), {nm, " close"});
      end else begin
        add(1'b0, 1'b0, 3'd0, 32'h0, endk == 0, endk == 1,
            eo(0, 0, 0, 3'd0, 32'h0, endk == 0, endk == 1), {nm, " end"});
      end
      open_cur = 1'b0;
    end else if (endk != 2) begin
      add(1'b0, 1'b0, 3'd0, 32'h0, endk == 0, endk == 1, 40'h0, {nm, " end"});
      add(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 40'h0, {nm, " idle"});
    end
  endtask

  task automatic drive_idle();
    rx_if.start = 1'b0; rx_if.data_valid = 1'b0; rx_if.bytes_valid = 3'd0;
    rx_if.data = 32'h0; rx_if.commit = 1'b0; rx_if.drop = 1'b0;
  endtask

  task automatic run_vecs();
    vec_t v;
    foreach (vq[i]) begin
      v = vq[i];
      @(negedge clk);
      rx_if.start = v.start; rx_if.data_valid = v.dv; rx_if.bytes_valid = v.bv;
      rx_if.data = v.data; rx_if.commit = v.commit; rx_if.drop = v.drop; promisc = v.prom;
      @(posedge clk);
      #1;
      check(v.name, outs(), v.exp_out);
      if (v.chk_hdr) begin
        check({v.name, " dst"}, dst_mac, v.e_dst);
        check({v.name, " src"}, src_mac, v.e_src);
        check({v.name, " type/vlan"}, {ethertype, vlan_valid, vlan_id}, {v.e_et, v.e_vv, v.e_vid});
      end
    end
    vq.delete();
    drive_idle();
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, " outs"}, outs(), 40'h0);
    check({nm, " dst"}, dst_mac, 48'h0);
    check({nm, " src"}, src_mac, 48'h0);
    check({nm, " type/vlan"}, {ethertype, vlan_valid, vlan_id}, 29'h0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; prom_cur = 1'b0; open_cur = 1'b0;
    rst_n = 1'b0; our_mac = OUR_MAC; promisc = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    add(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 40'h0, "idle");
    add(1'b0, 1'b1, 3'd4, 32'hDEAD_BEEF, 1'b0, 1'b0, 40'h0, "idle dv ignored");
    add_frame(OUR_MAC, 1'b0, 16'h0, 16'h0800, 46, 0, "basic");
    add_frame(48'h02_00_00_00_00_02, 1'b0, 16'h0, 16'h0800, 46, 0, "reject");
    prom_cur = 1'b1;
    add_frame(48'h02_00_00_00_00_02, 1'b0, 16'h0, 16'h0800, 47, 0, "promisc c3");
    prom_cur = 1'b0;
    add_frame(48'hFF_FF_FF_FF_FF_FF, 1'b0, 16'h0, 16'h0806, 49, 0, "bcast c1");
    add_frame(OUR_MAC, 1'b1, 16'h6064, 16'h86DD, 20, 0, "vlan");
    add_frame(OUR_MAC, 1'b0, 16'h0, 16'h0800, 20, 1, "drop");
    add_frame(OUR_MAC, 1'b0, 16'h0, 16'h0800, 10, 2, "open1");
    add_frame(OUR_MAC, 1'b0, 16'h0, 16'h0800, 8, 0, "restart");
    add_frame(OUR_MAC, 1'b0, 16'h0, 16'h0800, 12, 2, "open2");
    add(1'b1, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0, eo(0, 0, 0, 3'd0, 32'h0, 0, 1), "start+commit");
    open_cur = 1'b0;
    add_frame(OUR_MAC, 1'b0, 16'h0, 16'h0800, 6, 0, "after sc");
    // Runt: second header word carries only three bytes.
    add(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 40'h0, "runt start");
    add(1'b0, 1'b1, 3'd4, 32'h0200_0000, 1'b0, 1'b0, 40'h0, "runt w0");
    add(1'b0, 1'b1, 3'd3, 32'h0001_0011, 1'b0, 1'b0, 40'h0, "runt w1");
    add(1'b0, 1'b1, 3'd4, 32'h2233_4455, 1'b0, 1'b0, 40'h0, "runt w2");
    add(1'b0, 1'b1, 3'd4, 32'h0800_0102, 1'b0, 1'b0, 40'h0, "runt w3");
    add(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0, 40'h0, "runt commit");
    add(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 40'h0, "runt idle");
    // Commit after only two header words.
    add(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 40'h0, "short start");
    add(1'b0, 1'b1, 3'd4, 32'h0200_0000, 1'b0, 1'b0, 40'h0, "short w0");
    add(1'b0, 1'b1, 3'd4, 32'h0001_0011, 1'b0, 1'b0, 40'h0, "short w1");
    add(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0, 40'h0, "short commit");
    add(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 40'h0, "short idle");
    add(1'b0, 1'b1, 3'd4, 32'h0800_0102, 1'b0, 1'b0, 40'h0, "short idle dv");
    add_frame(OUR_MAC, 1'b0, 16'h0, 16'h0800, 4, 0, "recover");
    run_vecs();

    // Reset asserted while the body is streaming.
    add_frame(OUR_MAC, 1'b0, 16'h0, 16'h0800, 10, 2, "rstmid");
    run_vecs();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    open_cur = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    add(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 40'h0, "post-reset idle0");
    add(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 40'h0, "post-reset idle1");
    add(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 40'h0, "post-reset idle2");
    add_frame(OUR_MAC, 1'b1, 16'h0123, 16'h0800, 9, 0, "post-reset");
    run_vecs();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
